lcd_ctrl: RTL and testbench

- Memory-mapped HD44780-style character-LCD controller, decoded at LCD_BASE_ADDR (0x0000_7030) in the LSU I/O region.
- Buffers CPU command/data writes in a 4-entry FIFO.
- Runs a power-up init sequence, then sequences each FIFO entry onto the LCD bus: setup, enable pulse, hold, execution wait.
- Gives software a busy/full/overflow status word.

---
 rtl/lcd_ctrl_pkg.sv | 42 ++++
 rtl/lcd_cmd_fifo.sv | 64 ++++++
 rtl/lcd_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the memory-mapped HD44780-style character-LCD
// controller: FSM state encoding, register offsets within the LCD I/O
// region, the power-up init command sequence and small helper functions.
package lcd_ctrl_pkg;

  // Region base in the LSU I/O map; the decode itself happens in the LSU.
  localparam logic [31:0] LCD_BASE_ADDR = 32'h0000_7030;

  // Byte offsets within the region.
  localparam logic [3:0] LCD_CMD_OFS  = 4'h0;
  localparam logic [3:0] LCD_DATA_OFS = 4'h4;
  localparam logic [3:0] LCD_STAT_OFS = 4'h8;
  localparam logic [3:0] LCD_CTRL_OFS = 4'hC;

  localparam int LCDSTATE_W = 3;

  typedef enum logic [LCDSTATE_W-1:0] {
    ST_PWRUP,
    ST_INIT_ISSUE,
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD,
    ST_EXEC
  } LcdState_e;

  // 8-bit function set, display on, clear, entry mode increment.
  localparam int         LCD_INIT_LEN  = 4;
  localparam logic [1:0] LCD_INIT_LAST = 2'd3;
  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long
  // execution wait; every other command and all data writes are short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data inside {8'h01, 8'h02, 8'h03});
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO holding queued LCD transfers as {rs, data} entries.
// Pointer-plus-count implementation; no bypass, so a pop only ever sees
// entries written on an earlier edge and full/empty reflect the pre-edge
// count.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full)
//   wdata    : entry to store
//   pop      : advance read pointer (ignored when empty)
//   rdata    : head entry, valid when !empty
//   full     : all entries occupied
//   empty    : no entries stored
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; empty/count gate every read, so clearing
  // it would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// Memory-mapped HD44780-style character-LCD controller.
// CPU stores to CMD/DATA are queued in a small FIFO; an FSM runs the
// power-up init sequence, then plays each entry onto the LCD bus as
// setup -> enable pulse -> hold -> execution wait. A status word exposes
// busy/full/init_done/overflow.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_sel        : LSU address decode hit for the LCD region
//   i_wen        : store strobe (qualified by i_sel)
//   i_addr       : byte offset 0x0 CMD, 0x4 DATA, 0x8 STATUS, 0xC CTRL
//   i_wdata      : store data
//   o_rdata      : combinational load data (0 when not selected)
//   o_lcd_data   : LCD DB[7:0]
//   o_lcd_rs     : 0 = command, 1 = data
//   o_lcd_rw     : always 0, the controller only writes
//   o_lcd_en     : LCD enable strobe
//   o_lcd_on     : LCD power/backlight (CTRL bit0)
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter int unsigned T_PWRUP     = 2_000_000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN        = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 1850,
  parameter int unsigned T_EXEC_LONG = 76_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_wen,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  // One down-counter serves every timed state, sized for the longest wait.
  localparam int unsigned T_MAX = max2(max2(max2(T_PWRUP, T_EXEC_LONG), max2(T_EXEC, T_EN)),
                                       max2(T_SETUP, T_HOLD));
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] LD_PWRUP     = T_PWRUP[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LD_SETUP     = T_SETUP[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LD_EN        = T_EN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LD_HOLD      = T_HOLD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LD_EXEC      = T_EXEC[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LD_EXEC_LONG = T_EXEC_LONG[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_LAST     = {{(CNT_W-1){1'b0}}, 1'b1};

  LcdState_e        state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_idx;
  logic             init_done;
  logic             overflow;

  logic             wr;
  logic             push;
  logic [8:0]       push_entry;
  logic             pop;
  logic [8:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             busy;
  logic             unused_wdata;

  // ---------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------
  assign wr         = i_sel && i_wen;
  assign push       = wr && ((i_addr == LCD_CMD_OFS) || (i_addr == LCD_DATA_OFS));
  assign push_entry = {(i_addr == LCD_DATA_OFS), i_wdata[7:0]};
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign busy       = !fifo_empty || (state != ST_IDLE);
  assign o_lcd_rw   = 1'b0;
  assign unused_wdata = ^i_wdata[31:8];

  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    o_rdata = '0;
    if (i_sel) begin
      case (i_addr)
        LCD_STAT_OFS: o_rdata = {28'd0, overflow, init_done, fifo_full, busy};
        LCD_CTRL_OFS: o_rdata = {31'd0, o_lcd_on};
        default:      o_rdata = '0;
      endcase
    end
  end

  // Overflow is sticky until software writes 1 to STATUS bit3. A push
  // while full is dropped even if a pop happens on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lcd_on <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr && (i_addr == LCD_CTRL_OFS)) o_lcd_on <= i_wdata[0];
      if (wr && (i_addr == LCD_STAT_OFS) && i_wdata[3]) overflow <= 1'b0;
      else if (push && fifo_full)                      overflow <= 1'b1;
    end
  end

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Bus sequencer. Each timed state loads its duration on entry and
  // leaves on the cycle the counter reads 1, so it lasts exactly that many
  // cycles. o_lcd_rs/o_lcd_data double as the transfer latch and keep the
  // last value while idle.
  // ---------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_PWRUP;
      cnt        <= LD_PWRUP;
      init_idx   <= '0;
      init_done  <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= '0;
    end else begin
      unique case (state)
        ST_PWRUP: begin
          if (cnt == CNT_LAST) begin
            init_idx <= '0;
            state    <= ST_INIT_ISSUE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_INIT_ISSUE: begin
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= LCD_INIT_SEQ[init_idx];
          cnt        <= LD_SETUP;
          state      <= ST_SETUP;
        end

        ST_IDLE: begin
          if (!fifo_empty) begin
            {o_lcd_rs, o_lcd_data} <= fifo_rdata;
            cnt                    <= LD_SETUP;
            state                  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == CNT_LAST) begin
            o_lcd_en <= 1'b1;
            cnt      <= LD_EN;
            state    <= ST_ENABLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_ENABLE: begin
          if (cnt == CNT_LAST) begin
            o_lcd_en <= 1'b0;
            cnt      <= LD_HOLD;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt == CNT_LAST) begin
            cnt   <= is_long_cmd(o_lcd_rs, o_lcd_data) ? LD_EXEC_LONG : LD_EXEC;
            state <= ST_EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_EXEC: begin
          if (cnt == CNT_LAST) begin
            if (init_done) begin
              state <= ST_IDLE;
            end else if (init_idx == LCD_INIT_LAST) begin
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              init_idx <= init_idx + 1'b1;
              state    <= ST_INIT_ISSUE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          o_lcd_en <= 1'b0;
          cnt      <= LD_PWRUP;
          state    <= ST_PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl, run with shortened timing
// (T_PWRUP=10, T_SETUP=2, T_EN=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=20).
// A monitor records every EN pulse (rs/data at rise, rise and fall edge
// numbers); scenario tasks compare those records and STATUS reads against
// hand-computed values.
module tb_lcd_ctrl;
  import lcd_ctrl_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic        i_sel;
  logic        i_wen;
  logic [3:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;

  lcd_ctrl #(
    .FIFO_DEPTH  (4),
    .T_PWRUP     (10),
    .T_SETUP     (2),
    .T_EN        (3),
    .T_HOLD      (1),
    .T_EXEC      (5),
    .T_EXEC_LONG (20)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sel      (i_sel),
    .i_wen      (i_wen),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fall;
  } pulse_t;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc   = 0;
  int     rst_cyc;
  logic   en_q  = 1'b0;
  pulse_t cur;
  pulse_t pulses[$];

  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // EN pulse recorder: cyc is the index of the posedge just taken.
  always @(posedge i_clk) begin
    cyc = cyc + 1;
    #1;
    if (o_lcd_en && !en_q) begin
      cur.rs   = o_lcd_rs;
      cur.data = o_lcd_data;
      cur.rise = cyc;
    end
    if (!o_lcd_en && en_q) begin
      cur.fall = cyc;
      pulses.push_back(cur);
    end
    en_q = o_lcd_en;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Bus helpers (no checking)
  // ---------------------------------------------------------------------
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    i_sel = 1'b1; i_wen = 1'b1; i_addr = addr; i_wdata = data;
    @(negedge i_clk);
    i_sel = 1'b0; i_wen = 1'b0; i_addr = '0; i_wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    i_sel = 1'b1; i_wen = 1'b0; i_addr = addr;
    #1;
    data  = o_rdata;
    i_sel = 1'b0; i_addr = '0;
  endtask

  task automatic wait_idle(input int budget, output int drop_cyc);
    logic [31:0] s;
    int k;
    k = 0;
    bus_read(LCD_STAT_OFS, s);
    while (s[0] && k < budget) begin
      @(negedge i_clk);
      bus_read(LCD_STAT_OFS, s);
      k++;
    end
    drop_cyc = cyc;
    n_vec++;
    if (s[0] !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", s[0], budget);
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while (pulses.size() < n && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    n_vec++;
    if (pulses.size() < n) begin
      n_err++;
      $display("FAIL wait_pulses: got %0d pulses, required %0d", pulses.size(), n);
    end
  endtask

  task automatic wait_en_high(input int budget);
    int k;
    k = 0;
    while (o_lcd_en !== 1'b1 && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    n_vec++;
    if (o_lcd_en !== 1'b1) begin
      n_err++;
      $display("FAIL wait_en_high: en=%b after %0d cycles, required 1", o_lcd_en, budget);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] s;
    i_rst = 1'b1; i_sel = 1'b0; i_wen = 1'b0; i_addr = '0; i_wdata = '0;
    repeat (3) @(negedge i_clk);
    i_rst   = 1'b0;
    rst_cyc = cyc;
    pulses.delete();
    n_vec++;
    if ({o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_rw, o_lcd_on} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: en=%b rs=%b data=%h rw=%b on=%b, required 0 0 00 0 1",
               o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_rw, o_lcd_on);
    end
    bus_read(LCD_STAT_OFS, s);
    n_vec++;
    if (s !== 32'h1) begin
      n_err++;
      $display("FAIL reset_status: got %h, required 00000001", s);
    end
  endtask

  // Checks the four init pulses relative to the reset edge rst_cyc.
  task automatic check_init(input string tag);
    logic [31:0] s;
    int d;
    wait_pulses(4, 300);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (pulses[i].rs !== 1'b0 || pulses[i].data !== init_seq[i] ||
          (pulses[i].fall - pulses[i].rise) != 3) begin
        n_err++;
        $display("FAIL %s_pulse%0d: rs=%b data=%h width=%0d, required 0 %h 3", tag, i,
                 pulses[i].rs, pulses[i].data, pulses[i].fall - pulses[i].rise, init_seq[i]);
      end
    end
    n_vec++;
    if (pulses[0].rise - rst_cyc != 13) begin
      n_err++;
      $display("FAIL %s_first_rise: %0d cycles after reset, required 13", tag, pulses[0].rise - rst_cyc);
    end
    // hold 1 + exec 5 + issue 1 + setup 2
    n_vec++;
    if (pulses[1].rise - pulses[0].fall != 9) begin
      n_err++;
      $display("FAIL %s_gap_short: %0d, required 9", tag, pulses[1].rise - pulses[0].fall);
    end
    n_vec++;
    if (pulses[3].rise - pulses[2].fall < 20) begin
      n_err++;
      $display("FAIL %s_gap_clear: %0d, required >= 20", tag, pulses[3].rise - pulses[2].fall);
    end
    wait_idle(100, d);
    bus_read(LCD_STAT_OFS, s);
    n_vec++;
    if (s !== 32'h4) begin
      n_err++;
      $display("FAIL %s_status_done: got %h, required 00000004", tag, s);
    end
  endtask

  task automatic test_init();
    check_init("init");
  endtask

  task automatic test_data_cmd();
    int d;
    pulses.delete();
    bus_write(LCD_DATA_OFS, 32'h41);
    bus_write(LCD_CMD_OFS, 32'hC0);
    wait_idle(200, d);
    n_vec++;
    if (pulses.size() != 2) begin
      n_err++;
      $display("FAIL dc_count: %0d pulses before busy dropped, required 2", pulses.size());
    end
    n_vec++;
    if (pulses[0].rs !== 1'b1 || pulses[0].data !== 8'h41 || (pulses[0].fall - pulses[0].rise) != 3) begin
      n_err++;
      $display("FAIL dc_first: rs=%b data=%h width=%0d, required 1 41 3",
               pulses[0].rs, pulses[0].data, pulses[0].fall - pulses[0].rise);
    end
    n_vec++;
    if (pulses[1].rs !== 1'b0 || pulses[1].data !== 8'hC0 || (pulses[1].fall - pulses[1].rise) != 3) begin
      n_err++;
      $display("FAIL dc_second: rs=%b data=%h width=%0d, required 0 C0 3",
               pulses[1].rs, pulses[1].data, pulses[1].fall - pulses[1].rise);
    end
    // busy drops only when the second EXEC ends: hold 1 + exec 5
    n_vec++;
    if (d - pulses[1].fall != 6) begin
      n_err++;
      $display("FAIL dc_busy_end: busy dropped %0d after EN fall, required 6", d - pulses[1].fall);
    end
    n_vec++;
    if (o_lcd_rs !== 1'b0 || o_lcd_data !== 8'hC0) begin
      n_err++;
      $display("FAIL dc_idle_hold: rs=%b data=%h, required 0 C0", o_lcd_rs, o_lcd_data);
    end
  endtask

  task automatic test_burst();
    logic [31:0] s;
    int d;
    // Burst while idle: the first entry is popped right away, so 5 fit.
    pulses.delete();
    for (int i = 0; i < 5; i++) bus_write(LCD_DATA_OFS, 32'h30 + i);
    bus_read(LCD_STAT_OFS, s);
    n_vec++;
    if (s !== 32'h7) begin
      n_err++;
      $display("FAIL burst_idle_status: got %h, required 00000007", s);
    end
    wait_idle(400, d);
    n_vec++;
    if (pulses.size() != 5) begin
      n_err++;
      $display("FAIL burst_idle_count: %0d pulses, required 5", pulses.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (pulses[i].rs !== 1'b1 || pulses[i].data !== 8'(8'h30 + i)) begin
        n_err++;
        $display("FAIL burst_idle_data%0d: rs=%b data=%h, required 1 %h", i,
                 pulses[i].rs, pulses[i].data, 8'(8'h30 + i));
      end
    end
    // Burst during a transfer: 4 fit, the 5th is dropped.
    pulses.delete();
    bus_write(LCD_DATA_OFS, 32'h50);
    wait_en_high(50);
    for (int i = 1; i <= 5; i++) bus_write(LCD_DATA_OFS, 32'h50 + i);
    bus_read(LCD_STAT_OFS, s);
    // busy|full|overflow with init_done also set
    n_vec++;
    if (s !== 32'hF) begin
      n_err++;
      $display("FAIL burst_ovf_status: got %h, required 0000000F", s);
    end
    bus_write(LCD_STAT_OFS, 32'h8);
    bus_read(LCD_STAT_OFS, s);
    n_vec++;
    if (s !== 32'h7) begin
      n_err++;
      $display("FAIL burst_ovf_clear: got %h, required 00000007", s);
    end
    wait_idle(400, d);
    n_vec++;
    if (pulses.size() != 5) begin
      n_err++;
      $display("FAIL burst_ovf_count: %0d pulses, required 5", pulses.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (pulses[i].data !== 8'(8'h50 + i)) begin
        n_err++;
        $display("FAIL burst_ovf_data%0d: data=%h, required %h", i, pulses[i].data, 8'(8'h50 + i));
      end
    end
  endtask

  task automatic test_exec_time();
    int d;
    pulses.delete();
    bus_write(LCD_CMD_OFS, 32'h01);
    wait_idle(200, d);
    // hold 1 + long exec 20
    n_vec++;
    if (pulses[0].data !== 8'h01 || d - pulses[0].fall != 21) begin
      n_err++;
      $display("FAIL exec_long: data=%h hold+exec=%0d, required 01 21", pulses[0].data, d - pulses[0].fall);
    end
    pulses.delete();
    bus_write(LCD_CMD_OFS, 32'h80);
    wait_idle(200, d);
    n_vec++;
    if (pulses[0].data !== 8'h80 || d - pulses[0].fall != 6) begin
      n_err++;
      $display("FAIL exec_short: data=%h hold+exec=%0d, required 80 6", pulses[0].data, d - pulses[0].fall);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    pulses.delete();
    bus_write(LCD_DATA_OFS, 32'h61);
    bus_write(LCD_DATA_OFS, 32'h62);
    bus_write(LCD_DATA_OFS, 32'h63);
    wait_en_high(50);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst   = 1'b0;
    rst_cyc = cyc;
    n_vec++;
    if (o_lcd_en !== 1'b0 || o_lcd_rs !== 1'b0 || o_lcd_data !== 8'h00) begin
      n_err++;
      $display("FAIL rmid_outputs: en=%b rs=%b data=%h, required 0 0 00", o_lcd_en, o_lcd_rs, o_lcd_data);
    end
    bus_read(LCD_STAT_OFS, s);
    n_vec++;
    if (s !== 32'h1) begin
      n_err++;
      $display("FAIL rmid_status: got %h, required 00000001", s);
    end
    pulses.delete();
    check_init("rmid");
    repeat (30) @(negedge i_clk);
    n_vec++;
    if (pulses.size() != 4) begin
      n_err++;
      $display("FAIL rmid_flushed: %0d pulses after reset, required 4", pulses.size());
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] s;
    int d;
    i_sel = 1'b1; i_wen = 1'b1; i_addr = LCD_CTRL_OFS; i_wdata = 32'h0;
    #1;
    n_vec++;
    if (o_lcd_on !== 1'b1) begin
      n_err++;
      $display("FAIL ctrl_before_edge: on=%b, required 1", o_lcd_on);
    end
    @(negedge i_clk);
    i_sel = 1'b0; i_wen = 1'b0; i_addr = '0;
    n_vec++;
    if (o_lcd_on !== 1'b0) begin
      n_err++;
      $display("FAIL ctrl_off: on=%b, required 0", o_lcd_on);
    end
    bus_read(LCD_CTRL_OFS, s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL ctrl_read0: got %h, required 00000000", s);
    end
    bus_write(LCD_CTRL_OFS, 32'hFFFF_FFFF);
    bus_read(LCD_CTRL_OFS, s);
    n_vec++;
    if (s !== 32'h1 || o_lcd_on !== 1'b1) begin
      n_err++;
      $display("FAIL ctrl_read1: got %h on=%b, required 00000001 1", s, o_lcd_on);
    end
    // Stores without i_sel are ignored.
    pulses.delete();
    i_sel = 1'b0; i_wen = 1'b1; i_addr = LCD_CTRL_OFS; i_wdata = 32'h0;
    @(negedge i_clk);
    i_addr = LCD_DATA_OFS; i_wdata = 32'h77;
    @(negedge i_clk);
    i_wen = 1'b0; i_addr = '0; i_wdata = '0;
    repeat (10) @(negedge i_clk);
    n_vec++;
    if (o_lcd_on !== 1'b1 || pulses.size() != 0) begin
      n_err++;
      $display("FAIL ctrl_nosel: on=%b pulses=%0d, required 1 0", o_lcd_on, pulses.size());
    end
    i_addr = LCD_CTRL_OFS;
    #1;
    n_vec++;
    if (o_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL ctrl_nosel_read: got %h, required 00000000", o_rdata);
    end
    i_addr = '0;
    bus_read(LCD_CMD_OFS, s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL read_cmd: got %h, required 00000000", s);
    end
    bus_read(LCD_DATA_OFS, s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL read_data: got %h, required 00000000", s);
    end
    wait_idle(20, d);
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_cmd();
    test_burst();
    test_exec_time();
    test_reset_mid();
    test_ctrl();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
